// File: rtl/seg_disp_arbiter_pkg.sv
// Shared types for the seven-segment display arbiter: FSM encoding,
// requester count, default timer limits and the display payload bundle.
package seg_disp_arbiter_pkg;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 20;
    localparam int POINT_W = 6;
    localparam int CNT_W   = 24;

    // 200 ms hold and 250 ms blink half-period at 50 MHz
    localparam logic [CNT_W-1:0] HOLD_MAX_DEF  = 24'd9_999_999;
    localparam logic [CNT_W-1:0] BLINK_MAX_DEF = 24'd12_499_999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [POINT_W-1:0] point;
        logic               sign;
    } disp_t;

    function automatic logic [1:0] pick_winner(input logic [NUM_REQ-1:0] r);
        if (r[0])      return 2'd0;
        else if (r[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/seg_disp_arbiter_if.sv
// Requester/display bundle: three requester sources in, one display stream out.
// master = requesters plus display consumer, slave = arbiter.
interface seg_disp_arbiter_if;
    import seg_disp_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] blink;
    logic [DATA_W-1:0]  data0, data1, data2;
    logic [POINT_W-1:0] point0, point1, point2;
    logic               sign0, sign1, sign2;
    logic [NUM_REQ-1:0] gnt;
    logic [DATA_W-1:0]  data;
    logic [POINT_W-1:0] point;
    logic               sign;
    logic               seg_en;
    logic               busy;

    modport master (
        output req, blink, data0, data1, data2, point0, point1, point2, sign0, sign1, sign2,
        input  gnt, data, point, sign, seg_en, busy
    );

    modport slave (
        input  req, blink, data0, data1, data2, point0, point1, point2, sign0, sign1, sign2,
        output gnt, data, point, sign, seg_en, busy
    );

endinterface

// File: rtl/seg_disp_arbiter_blink_gen.sv
// Blink phase generator: counts 0..MAX while enabled, toggles ph on wrap; clr parks ph high.
// Latency 1 edge; no backpressure.
module seg_blink_gen
    import seg_disp_arbiter_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX = BLINK_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    input  logic clr,
    output logic ph
);

    logic [CNT_W-1:0] blink_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            blink_cnt <= '0;
            ph        <= 1'b1;
        end else if (en) begin
            if (blink_cnt == MAX) begin
                blink_cnt <= '0;
                ph        <= ~ph;
            end else begin
                blink_cnt <= blink_cnt + 24'd1;
            end
        end
    end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Fixed-priority display owner arbiter with minimum hold, blank slot on owner change and blink.
// Latency 1 edge req->grant, 2 edges owner change; no backpressure (requesters hold req high).
module seg_disp_arbiter
    import seg_disp_arbiter_pkg::*;
#(
    parameter logic [CNT_W-1:0] HOLD_MAX  = HOLD_MAX_DEF,
    parameter logic [CNT_W-1:0] BLINK_MAX = BLINK_MAX_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    seg_disp_arbiter_if.slave bus
);

    state_t             state;
    logic [1:0]         owner;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    disp_t              disp_q;
    logic [CNT_W-1:0]   hold_cnt;
    logic               blink_ph;

    logic [1:0] winner;
    disp_t      owner_src;
    disp_t      winner_src;
    logic       hold_done;
    logic       preempt;
    logic       leave;
    logic       blink_en;

    always_comb begin
        winner     = pick_winner(bus.req);
        owner_src  = '0;
        winner_src = '0;
        case (owner)
            2'd0:    owner_src = {bus.data0, bus.point0, bus.sign0};
            2'd1:    owner_src = {bus.data1, bus.point1, bus.sign1};
            2'd2:    owner_src = {bus.data2, bus.point2, bus.sign2};
            default: owner_src = '0;
        endcase
        case (winner)
            2'd0:    winner_src = {bus.data0, bus.point0, bus.sign0};
            2'd1:    winner_src = {bus.data1, bus.point1, bus.sign1};
            2'd2:    winner_src = {bus.data2, bus.point2, bus.sign2};
            default: winner_src = '0;
        endcase
        hold_done = (hold_cnt == HOLD_MAX);
        // only strictly higher-priority requesters may preempt, and only once the hold expires
        preempt   = hold_done && (|(bus.req & (onehot(owner) - 3'd1)));
        leave     = (state == ST_GRANT) && (!bus.req[owner] || preempt);
        blink_en  = (state == ST_GRANT) && !leave && bus.blink[owner];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            owner    <= 2'd0;
            gnt      <= '0;
            busy     <= 1'b0;
            disp_q   <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_SWITCH: begin
                    if (|bus.req) begin
                        state    <= ST_GRANT;
                        owner    <= winner;
                        gnt      <= onehot(winner);
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        disp_q   <= winner_src;
                    end else begin
                        state    <= ST_IDLE;
                        disp_q   <= '0;
                    end
                end
                ST_GRANT: begin
                    disp_q <= owner_src;
                    if (leave) begin
                        state <= ST_SWITCH;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else if (!hold_done) begin
                        hold_cnt <= hold_cnt + 24'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // phase is forced high whenever blink is off, so busy alone gates the blank slot
    seg_blink_gen #(
        .MAX (BLINK_MAX)
    ) u_blink (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (blink_en),
        .clr     (!blink_en),
        .ph      (blink_ph)
    );

    assign bus.gnt    = gnt;
    assign bus.busy   = busy;
    assign bus.data   = disp_q.data;
    assign bus.point  = disp_q.point;
    assign bus.sign   = disp_q.sign;
    assign bus.seg_en = busy & blink_ph;

endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
- Shares the single 6-digit dynamic seven-segment display among three requesters (e.g. counter, clock, sensor readout).
- Sits directly upstream of the dynamic display driver and drives its data/point/sign/seg_en inputs.
- Fixed-priority arbitration with a minimum-hold timer, so a higher-priority request cannot make the display flicker between owners.
- Adds a one-cycle blanking slot on every owner change, plus optional per-requester blink.

Parameters:
- HOLD_MAX, 24'd9_999_999: minimum ownership time in sys_clk cycles minus 1 (200 ms at 50 MHz).
- BLINK_MAX, 24'd12_499_999: blink half-period in sys_clk cycles minus 1 (250 ms at 50 MHz).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req  in  3  request per requester; bit 0 highest priority; held high for as long as display is wanted.
- blink  in  3  per-requester blink enable, sampled for the current owner only.
- data0, data1, data2  in  20 each  binary value from requester n.
- point0, point1, point2  in  6 each  decimal-point mask from requester n.
- sign0, sign1, sign2  in  1 each  negative flag from requester n.
- gnt  out  3  one-hot grant; all zero when no owner.
- data  out  20  to display driver.
- point  out  6  to display driver.
- sign  out  1  to display driver.
- seg_en  out  1  to display driver; 0 = blank.
- busy  out  1  1 while an owner holds the display.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high (sys_rst). While sys_rst=1 at a rising edge, every register clears on that edge:
  - state=IDLE, gnt=0, data=0, point=0, sign=0, seg_en=0, busy=0, hold_cnt=0, blink_cnt=0, blink_ph=1.
  - Reset mid-ownership drops the grant on that edge with no SWITCH slot.
- States: IDLE, GRANT, SWITCH (2-bit encoding). owner is a 2-bit index, valid in GRANT.
- Winner: lowest set index of req. Ties are impossible because the priority is fixed.
- IDLE:
  - req=0: stay; all outputs 0.
  - req!=0: next edge goes to GRANT with owner=winner, gnt=onehot(winner), busy=1, seg_en=1, hold_cnt=0, blink_cnt=0, blink_ph=1.
  - data/point/sign load from the winner on that same edge.
- GRANT, each edge:
  - data/point/sign <= owner's inputs, i.e. live tracking with 1-cycle latency.
  - hold_cnt increments and saturates at HOLD_MAX; hold_done = (hold_cnt==HOLD_MAX).
- GRANT exit conditions, evaluated in order:
  - a) req[owner]=0 -> SWITCH immediately, regardless of hold_cnt.
  - b) hold_done=1 and req has a set bit of lower index than owner -> SWITCH (preemption).
  - Lower-priority requests never preempt. Same-owner re-request is a no-op.
- SWITCH: exactly one cycle with gnt=0, seg_en=0, busy=0; data/point/sign hold their last values. Next edge:
  - req!=0 -> GRANT with the winner, initialised as from IDLE.
  - otherwise -> IDLE, with data/point/sign cleared to 0.
- Blink, GRANT only:
  - If blink[owner]=1, blink_cnt counts 0..BLINK_MAX and wraps; on wrap blink_ph toggles; seg_en = blink_ph.
  - If blink[owner]=0, blink_cnt=0, blink_ph=1, seg_en=1.
  - Blink deassertion mid-blank restores seg_en=1 on the next edge.
- Latency:
  - req rise (from IDLE) to gnt/seg_en/data valid: 1 edge.
  - Owner req fall to gnt=0: 1 edge.
  - Owner change: 2 edges (SWITCH slot plus grant).
- Widths:
  - hold_cnt and blink_cnt are 24-bit. Parameters wider than 24 bits are illegal.
  - No arithmetic on data; it is a pure pass-through.

Decomposition:
- Shared package: state encodings (ST_IDLE=2'd0, ST_GRANT=2'd1, ST_SWITCH=2'd2), NUM_REQ=3, and the default HOLD_MAX and BLINK_MAX at 50 MHz.
- One natural sub-module: seg_blink_gen (counter plus phase flop with enable and sync clear), instantiated once.
- Priority encoder and mux stay inline.

Test Plan (HOLD_MAX=9, BLINK_MAX=3):
- Reset, then req=3'b010 with data1=20'd1234, point1=6'b000100 -> one edge later: gnt=3'b010, seg_en=1, busy=1, data=1234, point=000100. Assert sys_rst mid-grant -> all outputs 0 on that edge.
- Owner 2 granted; raise req[0] at hold_cnt=3 -> gnt stays 3'b100 until hold_cnt=9. Then one SWITCH cycle (gnt=0, seg_en=0), then gnt=3'b001 with data=data0.
- Owner 0 granted; raise req[1] and hold 20 cycles -> gnt stays 3'b001 throughout (no low-priority preemption).
- Owner 1 drops req at hold_cnt=2 while req[2]=1 -> next edge SWITCH, following edge gnt=3'b100, hold_cnt restarts at 0.
- Owner 0 with blink[0]=1 -> seg_en pattern 1111 0000 1111 repeating (4 cycles per phase). Drop blink[0] during a 0 phase -> seg_en=1 next edge.
- Sole owner drops req with req=0 -> SWITCH then IDLE; data=0, point=0, sign=0, busy=0 after 2 edges.
